// File: rtl/layer_sequencer.sv
// layer_sequencer: steps one fully-connected layer through clear/MAC/activation/write per neuron.
// Optional LAYER_SEQ_PERF_EN adds a saturating cycle_cnt covering the busy and done cycles.
module layer_sequencer #(
  parameter int N_NEURONS = 4,
  parameter int CNT_W     = 3,
  parameter int IDX_W     = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [N_NEURONS*CNT_W-1:0] n_inputs,
  output logic                       busy,
  output logic                       done,
  output logic                       mac_clr,
  output logic                       mac_en,
  output logic [CNT_W-1:0]           in_addr,
  output logic [IDX_W+CNT_W-1:0]     w_addr,
  output logic                       act_valid,
  input  logic                       act_ready,
  output logic                       out_we,
  output logic [IDX_W-1:0]           out_addr
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]                cycle_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, CLR, MAC, ACT, WR, DONE} state_t;
  state_t state, nxt;
  logic [N_NEURONS*CNT_W-1:0] snap;
  logic [IDX_W-1:0] k;
  logic [CNT_W-1:0] i;
  logic [CNT_W-1:0] n_k;
  logic last_k, last_i, accept;
  assign n_k = snap[k*CNT_W +: CNT_W];
  assign last_k = k == IDX_W'(N_NEURONS-1);
  assign last_i = i == n_k - CNT_W'(1);
  assign accept = state == IDLE && start;
  assign in_addr = i;
  assign w_addr = {k, i};
  assign out_addr = k;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLR : IDLE;
      CLR:     nxt = n_k == '0 ? ACT : MAC;
      MAC:     nxt = last_i ? ACT : MAC;
      ACT:     nxt = act_ready ? WR : ACT;
      WR:      nxt = last_k ? DONE : CLR;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Strobes are registered from the next state so each lines up with its state cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      snap      <= '0;
      k         <= '0;
      i         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      act_valid <= 1'b0;
      out_we    <= 1'b0;
    end else begin
      state     <= nxt;
      busy      <= nxt inside {CLR, MAC, ACT, WR};
      done      <= nxt == DONE;
      mac_clr   <= nxt == CLR;
      mac_en    <= nxt == MAC;
      act_valid <= nxt == ACT;
      out_we    <= nxt == WR;
      if (accept) begin
        snap <= n_inputs;
        k    <= '0;
      end
      if (state == WR && !last_k) k <= k + 1'b1;
      if (state == CLR) i <= '0;
      else if (state == MAC && !last_i) i <= i + 1'b1;
    end
  end
`ifdef LAYER_SEQ_PERF_EN
  // Acceptance clears the count and credits the first busy cycle in the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_cnt <= '0;
    else if (accept) cycle_cnt <= 32'd1;
    else if (nxt != IDLE && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: random layers checked against a per-cycle transaction list model.
module tb_layer_sequencer;
  localparam int N = 4, CW = 3, IW = 2, NW = N*CW;
  localparam logic [2:0] K_CLR = 0, K_MAC = 1, K_ACT = 2, K_WR = 3, K_DONE = 4;
  typedef struct packed {logic [2:0] kind; logic [31:0] k; logic [31:0] i;} item_t;
  logic clk = 0, reset_n, start, act_ready;
  logic [NW-1:0] n_inputs;
  logic busy, done, mac_clr, mac_en, act_valid, out_we;
  logic [CW-1:0] in_addr;
  logic [IW+CW-1:0] w_addr;
  logic [IW-1:0] out_addr;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] cycle_cnt;
`endif
  int checks = 0, failures = 0;
  item_t q[$];
  layer_sequencer #(.N_NEURONS(N), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n_inputs(n_inputs),
    .busy(busy), .done(done), .mac_clr(mac_clr), .mac_en(mac_en),
    .in_addr(in_addr), .w_addr(w_addr), .act_valid(act_valid),
    .act_ready(act_ready), .out_we(out_we), .out_addr(out_addr)
`ifdef LAYER_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] flags_of(input logic [2:0] kind);
    case (kind)
      K_CLR:   return 6'b101000;
      K_MAC:   return 6'b100100;
      K_ACT:   return 6'b100010;
      K_WR:    return 6'b100001;
      K_DONE:  return 6'b010000;
      default: return 6'b000000;
    endcase
  endfunction
  function automatic logic [5:0] flags_now();
    return {busy, done, mac_clr, mac_en, act_valid, out_we};
  endfunction
  task automatic build(input logic [NW-1:0] nv);
    q.delete();
    for (int k = 0; k < N; k++) begin
      int nk = int'(nv[k*CW +: CW]);
      q.push_back('{K_CLR, k, 0});
      for (int i = 0; i < nk; i++) q.push_back('{K_MAC, k, i});
      q.push_back('{K_ACT, k, 0});
      q.push_back('{K_WR, k, 0});
    end
    q.push_back('{K_DONE, 0, 0});
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, 32'(flags_now()), 0);
    chk({tag, "_addr"}, 32'({in_addr, w_addr, out_addr}), 0);
`ifdef LAYER_SEQ_PERF_EN
    chk({tag, "_cnt"}, cycle_cnt, 0);
`endif
  endtask
  // mode 0: ready always; 1: random ready; 2: ready held low 5 cycles in neuron 2 ACT
  task automatic run_layer(input logic [NW-1:0] nv, input int mode, input bit disturb, input bit abort);
    int cyc = 0, stalls = 0, act_cnt = 0, base = 1;
    bit aborted = 0;
    item_t h;
    logic ar;
    for (int k = 0; k < N; k++) base += int'(nv[k*CW +: CW]) + 3;
    n_inputs = nv;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    build(nv);
    while (q.size() > 0 && cyc < 2000 && !aborted) begin
      cyc++;
      h = q[0];
      ar = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) :
           !(h.kind == K_ACT && h.k == 2 && act_cnt < 5);
      act_ready = ar;
      if (disturb) begin
        start = cyc == 5 || cyc == 9;
        if (cyc == 5) n_inputs = NW'($urandom);
      end
      if (abort && h.kind == K_MAC && h.k == 2) begin
        @(negedge clk);
        reset_n = 0;
        #1;
        check_zero("abort");
        q.delete();
        aborted = 1;
        @(posedge clk); #1;
        reset_n = 1;
      end else begin
        @(negedge clk);
        chk("flags", 32'(flags_now()), 32'(flags_of(h.kind)));
        if (h.kind == K_MAC) begin
          chk("in_addr", 32'(in_addr), h.i);
          chk("w_addr", 32'(w_addr), h.k * (1 << CW) + h.i);
        end
        if (h.kind == K_WR) chk("out_addr", 32'(out_addr), h.k);
        if (h.kind == K_ACT && !ar) begin
          stalls++;
          act_cnt++;
        end else begin
          if (h.kind == K_ACT) act_cnt = 0;
          void'(q.pop_front());
        end
        if (h.kind == K_DONE) begin
          chk("latency", cyc, base + stalls);
`ifdef LAYER_SEQ_PERF_EN
          chk("cycle_cnt", cycle_cnt, base + stalls);
`endif
        end
        @(posedge clk); #1;
      end
    end
    chk("drained", q.size(), 0);
    start = 0;
    act_ready = 0;
    @(negedge clk);
    chk("idle_flags", 32'(flags_now()), 0);
`ifdef LAYER_SEQ_PERF_EN
    if (!aborted) chk("cnt_hold", cycle_cnt, base + stalls);
`endif
    @(posedge clk); #1;
  endtask
  initial begin
    reset_n = 1;
    start = 0;
    act_ready = 0;
    n_inputs = '0;
    #2 reset_n = 0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    run_layer({3'd4, 3'd3, 3'd2, 3'd1}, 0, 0, 0);
    run_layer({3'($urandom), 3'($urandom), 3'd0, 3'($urandom)}, 1, 0, 0);
    run_layer({3'd2, 3'd1, 3'd2, 3'd3}, 2, 0, 0);
    run_layer({3'd3, 3'd2, 3'd5, 3'd1}, 1, 1, 0);
    run_layer({3'($urandom), 3'd3, 3'($urandom), 3'($urandom)}, 0, 0, 1);
    run_layer({3'd1, 3'd2, 3'd3, 3'd4}, 0, 0, 0);
    run_layer({3'd7, 3'd7, 3'd7, 3'd7}, 0, 0, 0);
    run_layer('0, 1, 0, 0);
    for (int t = 0; t < 15; t++) run_layer(NW'($urandom), 1, t[0], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
